// File: rtl/elevator_sched.sv
// -----------------------------------------------------------------------------
// elevator_sched
//
// Single-car elevator scheduler. Hall and car-panel calls are edge detected
// and latched as pending requests. A three-state controller (IDLE / MOVE / DOOR)
// serves them: it keeps travelling in the current direction while calls
// remain beyond the car, and reverses only from IDLE.
//
// Floor k of the building maps to bit k-1 of every floor vector.
//
// Optional feature macro: DOOR_HOLD_EN
//   defined   : in DOOR, bt_door_open (level) reloads the door timer and a
//               rising edge on bt_door_close ends the stop on the next edge.
//               bt_door_open wins when both are active.
//   undefined : both door buttons are ignored; the door stays open for
//               exactly DOOR_CYC cycles.
//
// Parameters
//   FLOORS      number of floors (2..16)
//   TRAVEL_CYC  clock cycles to move one floor
//   DOOR_CYC    clock cycles the door stays open per stop
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   btup             hall up calls (top floor bit ignored)
//   btdn             hall down calls (bottom floor bit ignored)
//   in_bt_floor      car panel floor calls
//   bt_door_open     car door-open button
//   bt_door_close    car door-close button
//   floor            one-hot current floor
//   led_state_up     travelling / committed upward
//   led_state_dn     travelling / committed downward
//   door_open        door open indication
//   reg_btup         pending hall up calls
//   reg_btdn         pending hall down calls
//   reg_in_bt_floor  pending car panel calls
// -----------------------------------------------------------------------------
module elevator_sched #(
    parameter int FLOORS     = 8,
    parameter int TRAVEL_CYC = 16,
    parameter int DOOR_CYC   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] btup,
    input  logic [FLOORS-1:0] btdn,
    input  logic [FLOORS-1:0] in_bt_floor,
    input  logic              bt_door_open,
    input  logic              bt_door_close,
    output logic [FLOORS-1:0] floor,
    output logic              led_state_up,
    output logic              led_state_dn,
    output logic              door_open,
    output logic [FLOORS-1:0] reg_btup,
    output logic [FLOORS-1:0] reg_btdn,
    output logic [FLOORS-1:0] reg_in_bt_floor
);

    localparam int TW = $clog2(TRAVEL_CYC + 1);
    localparam int DW = $clog2(DOOR_CYC + 1);

    // No up call exists at the top floor and no down call at the bottom.
    localparam logic [FLOORS-1:0] UP_VALID = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_VALID = {{(FLOORS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR
    } state_t;

    state_t            state_reg;
    logic [FLOORS-1:0] floor_reg;
    logic              up_reg;
    logic              dn_reg;
    logic              door_open_reg;
    logic [TW-1:0]     travel_cnt_reg;
    logic [DW-1:0]     door_cnt_reg;

    logic [FLOORS-1:0] btup_prev_reg;
    logic [FLOORS-1:0] btdn_prev_reg;
    logic [FLOORS-1:0] in_prev_reg;

    logic [FLOORS-1:0] pend_up_reg;
    logic [FLOORS-1:0] pend_dn_reg;
    logic [FLOORS-1:0] pend_in_reg;
    logic [FLOORS-1:0] pend_up_next;
    logic [FLOORS-1:0] pend_dn_next;
    logic [FLOORS-1:0] pend_in_next;

    logic [FLOORS-1:0] up_rise;
    logic [FLOORS-1:0] dn_rise;
    logic [FLOORS-1:0] in_rise;

    logic [FLOORS-1:0] above_mask;
    logic [FLOORS-1:0] below_mask;
    logic [FLOORS-1:0] all_pend;
    logic [FLOORS-1:0] next_floor;
    logic [FLOORS-1:0] beyond_pend;
    logic [FLOORS-1:0] same_hall;
    logic [FLOORS-1:0] clr_up;
    logic [FLOORS-1:0] clr_dn;
    logic [FLOORS-1:0] clr_in;

    logic              at_limit;
    logic              travel_done;
    logic              beyond_empty;
    logic              arrive_stop;
    logic              idle_here;
    logic              idle_above;
    logic              idle_below;

    logic              door_hold;
    logic              door_close_rise;

    // -------------------------------------------------------------------------
    // Door buttons
    // -------------------------------------------------------------------------
`ifdef DOOR_HOLD_EN
    logic close_prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            close_prev_reg <= 1'b0;
        end else begin
            close_prev_reg <= bt_door_close;
        end
    end

    assign door_hold       = bt_door_open;
    assign door_close_rise = bt_door_close & ~close_prev_reg;
`else
    logic door_btn_unused;

    assign door_btn_unused = bt_door_open | bt_door_close;
    assign door_hold       = 1'b0;
    assign door_close_rise = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Floors strictly above / below the car, derived from the one-hot floor
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < FLOORS; gi++) begin : g_mask
        if (gi == 0) begin : g_above_bottom
            assign above_mask[gi] = 1'b0;
        end else begin : g_above
            assign above_mask[gi] = |floor_reg[gi-1:0];
        end

        if (gi == FLOORS - 1) begin : g_below_top
            assign below_mask[gi] = 1'b0;
        end else begin : g_below
            assign below_mask[gi] = |floor_reg[FLOORS-1:gi+1];
        end
    end

    // -------------------------------------------------------------------------
    // Call edge detection; a held level produces a single rising edge
    // -------------------------------------------------------------------------
    assign up_rise = btup & ~btup_prev_reg & UP_VALID;
    assign dn_rise = btdn & ~btdn_prev_reg & DN_VALID;
    assign in_rise = in_bt_floor & ~in_prev_reg;

    // Clears win over a set arriving in the same cycle.
    assign pend_up_next = (pend_up_reg | up_rise) & ~clr_up;
    assign pend_dn_next = (pend_dn_reg | dn_rise) & ~clr_dn;
    assign pend_in_next = (pend_in_reg | in_rise) & ~clr_in;

    // -------------------------------------------------------------------------
    // Scheduling decisions
    // -------------------------------------------------------------------------
    always_comb begin
        all_pend    = pend_up_reg | pend_dn_reg | pend_in_reg;
        next_floor  = up_reg ? (floor_reg << 1) : (floor_reg >> 1);
        at_limit    = up_reg ? floor_reg[FLOORS-1] : floor_reg[0];
        same_hall   = up_reg ? pend_up_reg : pend_dn_reg;
        // Calls strictly beyond the floor being arrived at.
        beyond_pend = all_pend & (up_reg ? above_mask : below_mask) & ~next_floor;
        beyond_empty = (beyond_pend == '0);
        arrive_stop = (|(next_floor & (pend_in_reg | same_hall))) || beyond_empty;
        travel_done = (travel_cnt_reg == TW'(TRAVEL_CYC - 1));
        idle_here   = |(all_pend & floor_reg);
        idle_above  = |(all_pend & above_mask);
        idle_below  = |(all_pend & below_mask);

        clr_up = '0;
        clr_dn = '0;
        clr_in = '0;
        case (state_reg)
            ST_IDLE: begin
                // Serving a call at a standing car: no direction is
                // committed, so every call at this floor is answered.
                if (idle_here) begin
                    clr_up = floor_reg;
                    clr_dn = floor_reg;
                    clr_in = floor_reg;
                end
            end
            ST_MOVE: begin
                if (travel_done && !at_limit && arrive_stop) begin
                    clr_in = next_floor;
                    if (up_reg) begin
                        clr_up = next_floor;
                        if (beyond_empty) begin
                            clr_dn = next_floor;
                        end
                    end else begin
                        clr_dn = next_floor;
                        if (beyond_empty) begin
                            clr_up = next_floor;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Input history and pending call registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btup_prev_reg <= '0;
            btdn_prev_reg <= '0;
            in_prev_reg   <= '0;
            pend_up_reg   <= '0;
            pend_dn_reg   <= '0;
            pend_in_reg   <= '0;
        end else begin
            btup_prev_reg <= btup;
            btdn_prev_reg <= btdn;
            in_prev_reg   <= in_bt_floor;
            pend_up_reg   <= pend_up_next;
            pend_dn_reg   <= pend_dn_next;
            pend_in_reg   <= pend_in_next;
        end
    end

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            floor_reg      <= FLOORS'(1);
            up_reg         <= 1'b0;
            dn_reg         <= 1'b0;
            door_open_reg  <= 1'b0;
            travel_cnt_reg <= '0;
            door_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    travel_cnt_reg <= '0;
                    if (idle_here) begin
                        state_reg     <= ST_DOOR;
                        door_open_reg <= 1'b1;
                        door_cnt_reg  <= DW'(DOOR_CYC);
                        up_reg        <= 1'b0;
                        dn_reg        <= 1'b0;
                    end else if (idle_above) begin
                        // Upward calls take priority over downward ones.
                        state_reg <= ST_MOVE;
                        up_reg    <= 1'b1;
                        dn_reg    <= 1'b0;
                    end else if (idle_below) begin
                        state_reg <= ST_MOVE;
                        up_reg    <= 1'b0;
                        dn_reg    <= 1'b1;
                    end else begin
                        up_reg <= 1'b0;
                        dn_reg <= 1'b0;
                    end
                end

                ST_MOVE: begin
                    if (travel_done) begin
                        travel_cnt_reg <= '0;
                        if (at_limit) begin
                            // Unreachable with consistent calls; keeps the
                            // car inside the shaft regardless.
                            state_reg <= ST_IDLE;
                        end else begin
                            floor_reg <= next_floor;
                            if (arrive_stop) begin
                                state_reg     <= ST_DOOR;
                                door_open_reg <= 1'b1;
                                door_cnt_reg  <= DW'(DOOR_CYC);
                            end
                        end
                    end else begin
                        travel_cnt_reg <= travel_cnt_reg + TW'(1);
                    end
                end

                ST_DOOR: begin
                    // Direction lights stay as they were while the door is open.
                    if (door_hold) begin
                        door_cnt_reg <= DW'(DOOR_CYC);
                    end else if (door_close_rise || door_cnt_reg == DW'(1)) begin
                        state_reg     <= ST_IDLE;
                        door_open_reg <= 1'b0;
                        door_cnt_reg  <= '0;
                    end else begin
                        door_cnt_reg <= door_cnt_reg - DW'(1);
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign floor           = floor_reg;
    assign led_state_up    = up_reg;
    assign led_state_dn    = dn_reg;
    assign door_open       = door_open_reg;
    assign reg_btup        = pend_up_reg;
    assign reg_btdn        = pend_dn_reg;
    assign reg_in_bt_floor = pend_in_reg;

endmodule
